// File: rtl/pulse_seq_pkg.sv
// Shared types, widths and power-up defaults for the pulse sequencer.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package pulse_seq_pkg;

   localparam int PER_W    = 32;
   localparam int CP_W     = 8;
   localparam int PBLOFF_W = 16;
   localparam int TMR_W    = 33;

   localparam logic [PER_W-1:0]    DEF_PER      = 32'd201000;
   localparam logic [PER_W-1:0]    DEF_P1WID    = 32'd30;
   localparam logic [PER_W-1:0]    DEF_DEL      = 32'd200;
   localparam logic [PER_W-1:0]    DEF_P2WID    = 32'd30;
   localparam logic [CP_W-1:0]     DEF_CP       = 8'd1;
   localparam logic                DEF_PU       = 1'b1;
   localparam logic                DEF_BL       = 1'b1;
   localparam logic [CP_W-1:0]     DEF_P_BL     = 8'd50;
   localparam logic [PBLOFF_W-1:0] DEF_P_BL_OFF = 16'd100;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEAD = 3'd1,
      P1   = 3'd2,
      DLY  = 3'd3,
      P2   = 3'd4,
      GAP  = 3'd5,
      TAIL = 3'd6,
      WAIT = 3'd7
   } state_t;

   // One period's worth of configuration, frozen at the start of each period.
   typedef struct packed {
      logic                pu;
      logic                bl;
      logic [PER_W-1:0]    per;
      logic [PER_W-1:0]    p1wid;
      logic [PER_W-1:0]    del;
      logic [PER_W-1:0]    p2wid;
      logic [CP_W-1:0]     cp;
      logic [CP_W-1:0]     p_bl;
      logic [PBLOFF_W-1:0] p_bl_off;
   } cfg_t;

   // A position in the sequence: the state plus the P2 pulses still owed after the current one.
   typedef struct packed {
      state_t          st;
      logic [CP_W-1:0] rem;
   } step_t;

   localparam cfg_t DEF_CFG = '{
      pu: DEF_PU, bl: DEF_BL, per: DEF_PER, p1wid: DEF_P1WID, del: DEF_DEL,
      p2wid: DEF_P2WID, cp: DEF_CP, p_bl: DEF_P_BL, p_bl_off: DEF_P_BL_OFF
   };

   // Cycles spent in a state; 33 bits so the doubled delay of a GAP cannot wrap.
   function automatic logic [TMR_W-1:0] state_dur(state_t st, cfg_t c);
      logic [TMR_W-1:0] d;
      case (st)
         LEAD:    d = c.bl ? {25'd0, c.p_bl} : '0;
         P1:      d = {1'b0, c.p1wid};
         DLY:     d = {1'b0, c.del};
         P2:      d = {1'b0, c.p2wid};
         GAP:     d = {c.del, 1'b0};
         TAIL:    d = c.bl ? {17'd0, c.p_bl_off} : '0;
         default: d = '0;
      endcase
      return d;
   endfunction

   // Successor of a state once it has finished, ignoring durations.
   function automatic step_t step_succ(step_t s, cfg_t c);
      step_t r;
      r = s;
      case (s.st)
         LEAD:    r.st = P1;
         P1:      r.st = (c.cp == '0) ? TAIL : DLY;
         DLY: begin
            r.st  = P2;
            r.rem = c.cp - 8'd1;
         end
         P2:      r.st = (s.rem != '0) ? GAP : TAIL;
         GAP: begin
            r.st  = P2;
            r.rem = s.rem - 8'd1;
         end
         default: r.st = WAIT;
      endcase
      return r;
   endfunction

   // Walk forward past zero-length states so they take no cycles at all.
   // A zero-width P2 with zero delay would loop GAP/P2 forever, so that whole
   // train collapses straight to TAIL; every other chain ends within a few steps.
   function automatic step_t step_resolve(step_t s, cfg_t c);
      step_t r;
      r = s;
      for (int i = 0; i < 8; i++) begin
         if (r.st != WAIT && r.st != IDLE && state_dur(r.st, c) == '0) begin
            if ((r.st == P2 || r.st == GAP) && c.p2wid == '0 && c.del == '0)
               r.st = TAIL;
            else
               r = step_succ(r, c);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/pulse_sequencer_seq_timer.sv
// Loadable 33-bit down-counter that times the dwell of each sequencer state.
// Latency: load visible next cycle; zero flag is combinational from the count.
// Backpressure: none; counts every cycle until it reaches zero and holds there.
module seq_timer
   import pulse_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             zero
);

   logic [TMR_W-1:0] cnt_q;

   // Load takes priority; otherwise count down and park at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (cnt_q != '0)
         cnt_q <= cnt_q - 33'd1;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Periodic NMR pulse sequencer: P1, optional CPMG P2 train, receiver-blanking gate.
// Latency: every output is registered, one cycle after the counter/state decision.
// Backpressure: none; free-running, inputs sampled once per period at counter zero.
module pulse_sequencer
   import pulse_seq_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        pu,
   input  logic [31:0] per,
   input  logic [31:0] p1wid,
   input  logic [31:0] del,
   input  logic [31:0] p2wid,
   input  logic [7:0]  cp,
   input  logic        bl,
   input  logic [7:0]  p_bl,
   input  logic [15:0] p_bl_off,
   output logic        sync,
   output logic        pulse,
   output logic        inhib,
   output logic        seq_active
);

   logic [PER_W-1:0] cnt_q, cnt_d, eff_per_m1;
   logic             run_q;
   logic             restart;
   cfg_t             shadow_q, live, cfg;
   state_t           state_q;
   logic [CP_W-1:0]  rem_q;
   step_t            cur, seed, nxt;
   logic             timed;
   logic             tmr_load, tmr_zero;
   logic [TMR_W-1:0] tmr_val;
   logic             sync_d, pulse_d, inhib_d, active_d;

   // Live inputs bundled; a period uses them only on its first cycle, the shadow afterwards.
   always_comb begin
      live.pu       = pu;
      live.bl       = bl;
      live.per      = per;
      live.p1wid    = p1wid;
      live.del      = del;
      live.p2wid    = p2wid;
      live.cp       = cp;
      live.p_bl     = p_bl;
      live.p_bl_off = p_bl_off;
      restart       = run_q && (cnt_q == '0);
      cfg           = restart ? live : shadow_q;
   end

   // Period counter: the first cycle out of reset parks at zero so sync appears immediately.
   always_comb begin
      eff_per_m1 = (cfg.per < 32'd2) ? 32'd1 : cfg.per - 32'd1;
      if (!run_q)
         cnt_d = '0;
      else if (cnt_q >= eff_per_m1)
         cnt_d = '0;
      else
         cnt_d = cnt_q + 32'd1;
   end

   // Counter, run flag and per-period configuration capture.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q    <= '0;
         run_q    <= 1'b0;
         shadow_q <= DEF_CFG;
      end else begin
         cnt_q <= cnt_d;
         run_q <= 1'b1;
         if (restart)
            shadow_q <= live;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= nxt.st;
         rem_q   <= nxt.rem;
      end
   end

   // Next state: counter zero restarts the sequence (truncating any run in progress);
   // otherwise advance when the current state's timer has run out.
   always_comb begin
      cur.st   = state_q;
      cur.rem  = rem_q;
      seed.st  = LEAD;
      seed.rem = cfg.cp;
      nxt      = cur;
      tmr_load = 1'b0;
      timed    = (state_q != IDLE) && (state_q != WAIT);
      if (restart) begin
         nxt      = step_resolve(seed, cfg);
         tmr_load = (nxt.st != WAIT);
      end else if (timed && tmr_zero) begin
         nxt      = step_resolve(step_succ(cur, cfg), cfg);
         tmr_load = (nxt.st != WAIT);
      end
      tmr_val = state_dur(nxt.st, cfg) - 33'd1;
   end

   seq_timer u_timer (
      .clk      (clk),
      .rst_n    (resetn),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // Output decode from the state being entered, so the registered outputs line up with it.
   always_comb begin
      sync_d   = (cnt_d == '0);
      pulse_d  = cfg.pu && (nxt.st == P1 || nxt.st == P2);
      inhib_d  = cfg.bl && (nxt.st != IDLE) && (nxt.st != WAIT);
      active_d = (nxt.st != IDLE) && (nxt.st != WAIT);
   end

   // Output registers; reset drops the RF and blanking gates asynchronously.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync       <= 1'b0;
         pulse      <= 1'b0;
         inhib      <= 1'b0;
         seq_active <= 1'b0;
      end else begin
         sync       <= sync_d;
         pulse      <= pulse_d;
         inhib      <= inhib_d;
         seq_active <= active_d;
      end
   end

endmodule

// File: doc/pulse_sequencer.md
PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 clk  input  1  system clock (201 MHz, 4.975 ns per cycle); all timing below is in clk cycles.
REQ-002 resetn  input  1  reset, asynchronous assert, active-low.
REQ-003 pu  input  1  pulse enable; 0 = pulse output held low, timing still runs.
REQ-004 per  input  32  period in cycles.
REQ-005 p1wid  input  32  first-pulse width.
REQ-006 del  input  32  delay from P1 end to first P2 start.
REQ-007 p2wid  input  32  refocusing-pulse width.
REQ-008 cp  input  8  number of P2 pulses; 0 = P1 only (FID).
REQ-009 bl  input  1  receiver-blocking enable.
REQ-010 p_bl  input  8  lead cycles from inhib rise to P1 start.
REQ-011 p_bl_off  input  16  cycles inhib stays high after the last pulse ends.
REQ-012 sync  output  1  one-cycle strobe at the first cycle of each period.
REQ-013 pulse  output  1  pulse gate to the RF switch.
REQ-014 inhib  output  1  receiver-protect gate.
REQ-015 seq_active  output  1  high while the sequencer is in any state other than WAIT or IDLE.

Function
REQ-016 A 32-bit period counter SHALL count 0..eff_per-1 and wrap; eff_per = max(per, 2).
REQ-017 On each counter==0 cycle, all inputs SHALL be captured into shadow registers; mid-period input changes SHALL NOT affect the current period.
REQ-018 sync SHALL be high exactly on the cycle the counter equals 0.
REQ-019 The FSM SHALL have states IDLE, LEAD, P1, DLY, P2, GAP, TAIL, WAIT.
REQ-020 At counter==0 the FSM SHALL enter LEAD if shadow bl=1 and p_bl>0, otherwise P1.
REQ-021 LEAD SHALL last p_bl cycles, P1 p1wid cycles, DLY del cycles, each P2 p2wid cycles, and each GAP 2*del cycles.
REQ-022 State-duration arithmetic SHALL use 33 bits; 2*del SHALL NOT wrap.
REQ-023 A state with duration 0 SHALL be skipped in zero cycles; no pulse edge SHALL be produced for it.
REQ-024 The transition sequence SHALL be P1 -> (cp=0 ? TAIL : DLY) -> P2 -> (remaining P2 > 0 ? GAP -> P2 : TAIL).
REQ-025 TAIL SHALL last p_bl_off cycles if bl=1 and 0 cycles otherwise, and SHALL then enter WAIT.
REQ-026 pulse SHALL equal shadow pu AND (state is P1 or P2), registered.
REQ-027 inhib SHALL equal shadow bl AND (state is LEAD, P1, DLY, P2, GAP or TAIL), registered.
REQ-028 All outputs SHALL be registered with a fixed 1-cycle latency from the state/counter decision.
REQ-029 If the counter wraps before the sequence completes, the sequence SHALL be truncated and restarted from REQ-020 on that same cycle; pulse and inhib SHALL drop for at least 0 cycles and SHALL NOT glitch.
REQ-030 If pu=0, timing SHALL be identical to pu=1, with pulse held at 0.

Reset
REQ-031 While resetn=0: counter=0, FSM=IDLE, shadows = power-up defaults (per 201000, p1wid 30, del 200, p2wid 30, cp 1, pu 1, bl 1, p_bl 50, p_bl_off 100), and all outputs 0.
REQ-032 The first sync SHALL occur on the first clk edge after resetn deasserts.
REQ-033 Reset asserted mid-pulse SHALL force pulse and inhib low asynchronously.

Structure
REQ-034 Package pulse_seq_pkg SHALL hold the state enum, the width constants (32/8/16) and the power-up defaults.
REQ-035 One sub-module, seq_timer (loadable 33-bit down-counter with a zero flag), SHALL time every state.

Verification
REQ-036 Defaults, pu=1, bl=1 -> sync every 201000 cycles; inhib rises at cycle 1; pulse high for cycles 51..80, low for 200 cycles, high for 30 cycles; inhib falls 100 cycles after the P2 end.
REQ-037 cp=3, del=10, p2wid=5, bl=0 -> three P2 pulses separated by 20-cycle gaps; inhib stays 0.
REQ-038 cp=0, p1wid=0 -> no pulse edges; sync continues.
REQ-039 per=100, with a sequence needing 300 cycles -> truncation at the wrap, restart, and no pulse glitch.
REQ-040 Change del mid-period -> the current period is unchanged and the next period uses the new del.
REQ-041 resetn pulsed low during P1 -> pulse low immediately; first sync on the first edge after release.
